// File: rtl/sata_align_ins.sv
// ALIGN-pair insertion on the TX stream toward the phy and ALIGN stripping on the RX stream.
// Optional receive statistics counters are compiled in when SATA_ALIGN_STATS_EN is defined.
module sata_align_ins #(
  parameter int DATA_BYTE_WIDTH = 4,
  parameter int ALIGN_PERIOD    = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        phy_ready,
  input  logic [31:0] tx_data_in,
  input  logic [3:0]  tx_charisk_in,
  input  logic        tx_valid_in,
  output logic        tx_ready_out,
  output logic [31:0] phy_data_out,
  output logic [3:0]  phy_charisk_out,
  input  logic [31:0] phy_data_in,
  input  logic [3:0]  phy_charisk_in,
  input  logic [3:0]  phy_err_in,
  output logic [31:0] rx_data_out,
  output logic [3:0]  rx_charisk_out,
  output logic        rx_valid_out,
`ifdef SATA_ALIGN_STATS_EN
  input  logic        stats_clr,
  output logic [15:0] rx_align_cnt,
  output logic [15:0] rx_err_cnt,
`endif
  output logic        rx_err_out
);

  localparam logic [31:0] ALIGN_PRIM = 32'h7B4A4ABC;
  localparam logic [31:0] SYNC_PRIM  = 32'hB5B5957C;
  localparam logic [3:0]  PRIM_K     = 4'b0001;
  localparam logic [7:0]  CNT_LAST   = 8'(ALIGN_PERIOD - 1);

  generate
    if (DATA_BYTE_WIDTH != 4) begin : g_bad_width
      $error("sata_align_ins: DATA_BYTE_WIDTH must be 4");
    end
    if (ALIGN_PERIOD < 4 || ALIGN_PERIOD > 256) begin : g_bad_period
      $error("sata_align_ins: ALIGN_PERIOD must be in 4..256");
    end
  endgenerate

  logic [7:0] cnt;
  logic       rx_is_align;

  // Slot counter: slots 0 and 1 of every period carry the ALIGN pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (!phy_ready || cnt == CNT_LAST) begin
      cnt <= 8'd0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign tx_ready_out = phy_ready & (cnt >= 8'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phy_data_out    <= ALIGN_PRIM;
      phy_charisk_out <= PRIM_K;
    end else if (!phy_ready || cnt < 8'd2) begin
      phy_data_out    <= ALIGN_PRIM;
      phy_charisk_out <= PRIM_K;
    end else if (tx_valid_in && tx_ready_out) begin
      phy_data_out    <= tx_data_in;
      phy_charisk_out <= tx_charisk_in;
    end else begin
      phy_data_out    <= SYNC_PRIM;
      phy_charisk_out <= PRIM_K;
    end
  end

  assign rx_is_align = (phy_charisk_in == PRIM_K) && (phy_data_in == ALIGN_PRIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_out    <= 32'd0;
      rx_charisk_out <= 4'd0;
      rx_valid_out   <= 1'b0;
      rx_err_out     <= 1'b0;
    end else begin
      rx_data_out    <= phy_data_in;
      rx_charisk_out <= phy_charisk_in;
      rx_valid_out   <= phy_ready & ~rx_is_align;
      rx_err_out     <= phy_ready & (|phy_err_in);
    end
  end

`ifdef SATA_ALIGN_STATS_EN
  // Counters track the input side, so they lead the matching rx_* outputs by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_align_cnt <= 16'd0;
      rx_err_cnt   <= 16'd0;
    end else if (stats_clr) begin
      rx_align_cnt <= 16'd0;
      rx_err_cnt   <= 16'd0;
    end else begin
      if (phy_ready && rx_is_align && rx_align_cnt != 16'hFFFF) begin
        rx_align_cnt <= rx_align_cnt + 16'd1;
      end
      if (phy_ready && (|phy_err_in) && rx_err_cnt != 16'hFFFF) begin
        rx_err_cnt <= rx_err_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sata_align_ins.sv
// Self-checking bench for sata_align_ins: a period-256 instance and a period-8 instance share stimulus.
`timescale 1ns/1ps
module tb_sata_align_ins;
  localparam logic [31:0] ALIGN_W = 32'h7B4A4ABC;
  localparam logic [31:0] SYNC_W  = 32'hB5B5957C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        phy_ready = 1'b0;
  logic [31:0] tx_data_in = 32'd0;
  logic [3:0]  tx_charisk_in = 4'd0;
  logic        tx_valid_in = 1'b0;
  logic [31:0] phy_data_in = 32'd0;
  logic [3:0]  phy_charisk_in = 4'd0;
  logic [3:0]  phy_err_in = 4'd0;

  logic        tx_ready_out, tx_ready8;
  logic [31:0] phy_data_out, phy_data8;
  logic [3:0]  phy_charisk_out, phy_charisk8;
  logic [31:0] rx_data_out, rx_data8;
  logic [3:0]  rx_charisk_out, rx_charisk8;
  logic        rx_valid_out, rx_valid8;
  logic        rx_err_out, rx_err8;
`ifdef SATA_ALIGN_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] rx_align_cnt, rx_err_cnt, rx_align_cnt8, rx_err_cnt8;
`endif

  int tests = 0;
  int fails = 0;
  logic [35:0] tx_q[$];
  logic [35:0] tx8_q[$];
  logic [37:0] rx_q[$];

  always #5 clk = ~clk;

  sata_align_ins #(.DATA_BYTE_WIDTH(4), .ALIGN_PERIOD(256)) dut (
    .clk(clk), .rst(rst), .phy_ready(phy_ready),
    .tx_data_in(tx_data_in), .tx_charisk_in(tx_charisk_in), .tx_valid_in(tx_valid_in),
    .tx_ready_out(tx_ready_out), .phy_data_out(phy_data_out), .phy_charisk_out(phy_charisk_out),
    .phy_data_in(phy_data_in), .phy_charisk_in(phy_charisk_in), .phy_err_in(phy_err_in),
    .rx_data_out(rx_data_out), .rx_charisk_out(rx_charisk_out), .rx_valid_out(rx_valid_out),
`ifdef SATA_ALIGN_STATS_EN
    .stats_clr(stats_clr), .rx_align_cnt(rx_align_cnt), .rx_err_cnt(rx_err_cnt),
`endif
    .rx_err_out(rx_err_out)
  );

  sata_align_ins #(.DATA_BYTE_WIDTH(4), .ALIGN_PERIOD(8)) dut8 (
    .clk(clk), .rst(rst), .phy_ready(phy_ready),
    .tx_data_in(tx_data_in), .tx_charisk_in(tx_charisk_in), .tx_valid_in(tx_valid_in),
    .tx_ready_out(tx_ready8), .phy_data_out(phy_data8), .phy_charisk_out(phy_charisk8),
    .phy_data_in(phy_data_in), .phy_charisk_in(phy_charisk_in), .phy_err_in(phy_err_in),
    .rx_data_out(rx_data8), .rx_charisk_out(rx_charisk8), .rx_valid_out(rx_valid8),
`ifdef SATA_ALIGN_STATS_EN
    .stats_clr(stats_clr), .rx_align_cnt(rx_align_cnt8), .rx_err_cnt(rx_err_cnt8),
`endif
    .rx_err_out(rx_err8)
  );

  task automatic test_reset();
    rst = 1'b1; phy_ready = 1'b0; tx_valid_in = 1'b1;
    tx_data_in = 32'hDEADBEEF; tx_charisk_in = 4'd0;
    phy_data_in = 32'h12345678; phy_charisk_in = 4'd0; phy_err_in = 4'hF;
    repeat (3) @(negedge clk);
    tests++;
    if ({rx_data_out, rx_charisk_out, rx_valid_out, rx_err_out} !== 38'd0) begin
      fails++;
      $display("FAIL reset_rx got=%h exp=0", {rx_data_out, rx_charisk_out, rx_valid_out, rx_err_out});
    end
    tests++;
    if (phy_data_out !== ALIGN_W || phy_charisk_out !== 4'b0001) begin
      fails++;
      $display("FAIL reset_tx got=%h/%b exp=%h/0001", phy_data_out, phy_charisk_out, ALIGN_W);
    end
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      tests++;
      if (phy_data_out !== ALIGN_W || phy_charisk_out !== 4'b0001) begin
        fails++;
        $display("FAIL noready_tx c=%0d got=%h/%b exp=%h/0001", c, phy_data_out, phy_charisk_out, ALIGN_W);
      end
      tests++;
      if (tx_ready_out !== 1'b0 || tx_ready8 !== 1'b0) begin
        fails++;
        $display("FAIL noready_rdy c=%0d got=%b%b exp=00", c, tx_ready_out, tx_ready8);
      end
      tests++;
      if (rx_valid_out !== 1'b0 || rx_err_out !== 1'b0) begin
        fails++;
        $display("FAIL noready_rx c=%0d got=%b%b exp=00", c, rx_valid_out, rx_err_out);
      end
    end
    phy_err_in = 4'd0;
  endtask

  task automatic test_stream();
    int slot;
    logic [31:0] nd;
    logic [35:0] exp;
    phy_ready = 1'b0;
    repeat (2) @(negedge clk);
    slot = 0; nd = 32'h0000_0100;
    phy_ready = 1'b1; tx_valid_in = 1'b1;
    for (int c = 0; c < 560; c++) begin
      tx_data_in = nd; tx_charisk_in = nd[3:0];
      #1;
      tests++;
      if (tx_ready_out !== (slot >= 2)) begin
        fails++;
        $display("FAIL stream_rdy c=%0d got=%b exp=%b", c, tx_ready_out, (slot >= 2));
      end
      if (slot < 2) tx_q.push_back({4'b0001, ALIGN_W});
      else tx_q.push_back({nd[3:0], nd});
      @(posedge clk); #1;
      exp = tx_q.pop_front();
      tests++;
      if ({phy_charisk_out, phy_data_out} !== exp) begin
        fails++;
        $display("FAIL stream_data c=%0d got=%h exp=%h", c, {phy_charisk_out, phy_data_out}, exp);
      end
      if (slot >= 2) nd++;
      slot = (slot == 255) ? 0 : slot + 1;
      @(negedge clk);
    end
  endtask

  task automatic test_sync();
    logic [35:0] exp;
    logic [31:0] exp256;
    phy_ready = 1'b0; tx_valid_in = 1'b0;
    repeat (2) @(negedge clk);
    phy_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      #1;
      tests++;
      if (tx_ready8 !== ((c % 8) >= 2)) begin
        fails++;
        $display("FAIL sync_rdy8 c=%0d got=%b exp=%b", c, tx_ready8, ((c % 8) >= 2));
      end
      tx8_q.push_back(((c % 8) < 2) ? {4'b0001, ALIGN_W} : {4'b0001, SYNC_W});
      exp256 = (c < 2) ? ALIGN_W : SYNC_W;
      @(posedge clk); #1;
      exp = tx8_q.pop_front();
      tests++;
      if ({phy_charisk8, phy_data8} !== exp) begin
        fails++;
        $display("FAIL sync_p8 c=%0d got=%h exp=%h", c, {phy_charisk8, phy_data8}, exp);
      end
      tests++;
      if (phy_data_out !== exp256 || phy_charisk_out !== 4'b0001) begin
        fails++;
        $display("FAIL sync_p256 c=%0d got=%h/%b exp=%h/0001", c, phy_data_out, phy_charisk_out, exp256);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_drop();
    int slot;
    logic pr, exp_rdy;
    logic [31:0] nd;
    logic [35:0] exp;
    phy_ready = 1'b0;
    repeat (2) @(negedge clk);
    slot = 0; nd = 32'hA000_0000;
    tx_valid_in = 1'b1;
    for (int c = 0; c < 120; c++) begin
      pr = !(c >= 100 && c < 103);
      phy_ready = pr;
      tx_data_in = nd; tx_charisk_in = 4'd0;
      #1;
      exp_rdy = pr && (slot >= 2);
      tests++;
      if (tx_ready_out !== exp_rdy) begin
        fails++;
        $display("FAIL drop_rdy c=%0d got=%b exp=%b", c, tx_ready_out, exp_rdy);
      end
      if (!pr || slot < 2) tx_q.push_back({4'b0001, ALIGN_W});
      else tx_q.push_back({4'b0000, nd});
      @(posedge clk); #1;
      exp = tx_q.pop_front();
      tests++;
      if ({phy_charisk_out, phy_data_out} !== exp) begin
        fails++;
        $display("FAIL drop_data c=%0d got=%h exp=%h", c, {phy_charisk_out, phy_data_out}, exp);
      end
      if (!pr) slot = 0;
      else begin
        if (slot >= 2) nd++;
        slot = (slot == 255) ? 0 : slot + 1;
      end
      @(negedge clk);
    end
    tx_valid_in = 1'b0;
  endtask

  task automatic test_rx();
    logic [31:0] d [6];
    logic [3:0]  k [6];
    logic [3:0]  e [6];
    logic        pr [6];
    logic        ev [6];
    logic        ee [6];
    logic [37:0] exp;
    d  = '{SYNC_W, ALIGN_W, 32'h12345678, ALIGN_W, ALIGN_W, 32'h0BADF00D};
    k  = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001};
    e  = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0100};
    pr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    ev = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    ee = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      phy_ready = pr[i]; phy_data_in = d[i]; phy_charisk_in = k[i]; phy_err_in = e[i];
      rx_q.push_back({ev[i], ee[i], k[i], d[i]});
      @(posedge clk); #1;
      exp = rx_q.pop_front();
      tests++;
      if ({rx_valid_out, rx_err_out, rx_charisk_out, rx_data_out} !== exp) begin
        fails++;
        $display("FAIL rx_word i=%0d got=%h exp=%h", i, {rx_valid_out, rx_err_out, rx_charisk_out, rx_data_out}, exp);
      end
      @(negedge clk);
    end
    phy_err_in = 4'd0;
  endtask

`ifdef SATA_ALIGN_STATS_EN
  task automatic test_stats();
    phy_ready = 1'b1; phy_data_in = 32'd0; phy_charisk_in = 4'd0; phy_err_in = 4'd0;
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    tests++;
    if (rx_align_cnt !== 16'd0 || rx_err_cnt !== 16'd0) begin
      fails++;
      $display("FAIL stats_clr0 got=%h/%h exp=0/0", rx_align_cnt, rx_err_cnt);
    end
    phy_data_in = ALIGN_W; phy_charisk_in = 4'b0001;
    for (int c = 0; c < 70000; c++) begin
      phy_err_in = (c < 10) ? 4'b1000 : 4'b0000;
      @(negedge clk);
      if (c == 4) begin
        tests++;
        if (rx_align_cnt !== 16'd5) begin
          fails++;
          $display("FAIL stats_early got=%0d exp=5", rx_align_cnt);
        end
      end
    end
    tests++;
    if (rx_align_cnt !== 16'hFFFF) begin
      fails++;
      $display("FAIL stats_sat got=%h exp=ffff", rx_align_cnt);
    end
    tests++;
    if (rx_err_cnt !== 16'd10) begin
      fails++;
      $display("FAIL stats_err got=%0d exp=10", rx_err_cnt);
    end
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    tests++;
    if (rx_align_cnt !== 16'd0 || rx_err_cnt !== 16'd0) begin
      fails++;
      $display("FAIL stats_clr_prio got=%h/%h exp=0/0", rx_align_cnt, rx_err_cnt);
    end
    @(negedge clk);
    tests++;
    if (rx_align_cnt !== 16'd1) begin
      fails++;
      $display("FAIL stats_resume got=%0d exp=1", rx_align_cnt);
    end
  endtask
`endif

  task automatic test_async_reset();
    phy_ready = 1'b1; tx_valid_in = 1'b0;
    phy_data_in = SYNC_W; phy_charisk_in = 4'b0001; phy_err_in = 4'd0;
    repeat (2) @(negedge clk);
    phy_ready = 1'b0;
    @(negedge clk);
    phy_ready = 1'b1;
    repeat (4) @(negedge clk);
    tests++;
    if (rx_valid_out !== 1'b1 || phy_data_out !== SYNC_W) begin
      fails++;
      $display("FAIL areset_pre got=%b/%h exp=1/%h", rx_valid_out, phy_data_out, SYNC_W);
    end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    tests++;
    if (phy_data_out !== ALIGN_W || phy_charisk_out !== 4'b0001 || tx_ready_out !== 1'b0) begin
      fails++;
      $display("FAIL areset_tx got=%h/%b/%b exp=%h/0001/0", phy_data_out, phy_charisk_out, tx_ready_out, ALIGN_W);
    end
    tests++;
    if ({rx_data_out, rx_charisk_out, rx_valid_out, rx_err_out} !== 38'd0) begin
      fails++;
      $display("FAIL areset_rx got=%h exp=0", {rx_data_out, rx_charisk_out, rx_valid_out, rx_err_out});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_sync();
    test_drop();
    test_rx();
`ifdef SATA_ALIGN_STATS_EN
    test_stats();
`endif
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sata_align_ins.md
Name: sata_align_ins

Overview:
- Sits between the link layer and the phy-level block (oob_ctrl/gtx_wrap), on the usrclk2 (sata clk) domain.
- TX side: inserts the mandatory ALIGN primitive pair every ALIGN_PERIOD dwords into the link-layer stream. Applies backpressure to the link layer during ALIGN slots and fills idle slots with SYNC.
- RX side: strips received ALIGN primitives, flags all other dwords valid, and forwards per-dword error to the link layer.

Parameters:
- DATA_BYTE_WIDTH, 4, bytes per word; only 4 is supported (elaboration error otherwise).
- ALIGN_PERIOD, 256, dwords per period including the ALIGN pair; legal range 4..256.

Ports:
- clk  in  1  sata clk (usrclk2); the block's only clock.
- rst  in  1  asynchronous, active-high reset.
- phy_ready  in  1  link established (from oob_ctrl).
- tx_data_in  in  32  link-layer TX dword.
- tx_charisk_in  in  4  K-flags for tx_data_in.
- tx_valid_in  in  1  tx_data_in holds a dword to send.
- tx_ready_out  out  1  block accepts tx_data_in this cycle.
- phy_data_out  out  32  TX dword to phy (ll_data_in).
- phy_charisk_out  out  4  TX K-flags to phy (ll_charisk_in).
- phy_data_in  in  32  RX dword from phy (ll_data_out).
- phy_charisk_in  in  4  RX K-flags (ll_charisk_out).
- phy_err_in  in  4  RX per-byte disparity/not-in-table error (ll_err_out).
- rx_data_out  out  32  RX dword to link layer.
- rx_charisk_out  out  4  RX K-flags to link layer.
- rx_valid_out  out  1  rx_data_out is a non-ALIGN dword.
- rx_err_out  out  1  OR of phy_err_in for that dword.

Behaviour:
- Constants:
  - ALIGN = 32'h7B4A4ABC, charisk 4'b0001.
  - SYNC = 32'hB5B5957C, charisk 4'b0001.
- Reset values:
  - phy_data_out = ALIGN, phy_charisk_out = 4'b0001.
  - rx_data_out = 0, rx_charisk_out = 0, rx_valid_out = 0, rx_err_out = 0.
  - Slot counter cnt = 0.
- TX slot counter:
  - cnt is 8 bits. If phy_ready = 0, cnt <= 0 every cycle.
  - Otherwise cnt <= (cnt == ALIGN_PERIOD-1) ? 0 : cnt+1. With ALIGN_PERIOD = 256 this is a natural wrap.
- tx_ready_out = phy_ready & (cnt >= 2). It is combinational from registered cnt and phy_ready only, with no dependence on tx_valid_in.
- TX output register (1-cycle latency), loaded every clk edge:
  - phy_ready = 0 → ALIGN.
  - cnt ∈ {0,1} → ALIGN.
  - tx_valid_in & tx_ready_out → tx_data_in / tx_charisk_in; the transfer completes at this edge.
  - Else → SYNC.
- Net effect: after phy_ready rises, the first two output dwords are ALIGN, followed by ALIGN_PERIOD-2 data/SYNC slots, repeating.
- phy_ready falling mid-period:
  - tx_ready_out drops in the same cycle, so no transfer is accepted.
  - cnt returns to 0 and output reverts to ALIGN on the next edge.
  - A subsequent rise restarts with an ALIGN pair.
- Link-layer handshake rule: tx_data_in, tx_charisk_in and tx_valid_in are held stable while tx_valid_in = 1 and tx_ready_out = 0. The block does not buffer.
- RX path (1-cycle registered latency). Each cycle:
  - rx_data_out <= phy_data_in; rx_charisk_out <= phy_charisk_in.
  - rx_valid_out <= phy_ready & ~(phy_charisk_in == 4'b0001 & phy_data_in == ALIGN).
  - rx_err_out <= phy_ready & |phy_err_in.
  - Non-ALIGN primitives (SYNC, X_RDY, …) pass with rx_valid_out = 1.
  - An erroneous ALIGN (error bits set) is still dropped from valid, but rx_err_out asserts.
- Reset asserted mid-operation: all outputs return to their reset values asynchronously. There is no pending state to flush.

Optional Feature:
- Macro: SATA_ALIGN_STATS_EN.
- When defined, adds:
  - out 16 rx_align_cnt: received ALIGNs.
  - out 16 rx_err_cnt: dwords with rx_err_out set.
  - in 1 stats_clr.
- Counters are saturating at 16'hFFFF, reset to 0 by rst or by stats_clr (synchronous).
- stats_clr has priority over a simultaneous increment.
- Counting is gated by phy_ready.
- When not defined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, phy_ready = 0, tx_valid_in = 1 → phy_data_out = 32'h7B4A4ABC every cycle, tx_ready_out = 0.
- Raise phy_ready, tx_valid_in held 1 with incrementing data → output ALIGN, ALIGN, then 254 data dwords; ALIGN pair recurs at offsets 256/257; no data dropped or duplicated.
- phy_ready = 1, tx_valid_in = 0 → SYNC (32'hB5B5957C, charisk 0001) in all non-ALIGN slots; ALIGN_PERIOD = 8 → period-8 pattern A,A,S×6.
- Drop phy_ready at cnt = 100 for 3 cycles, then restore → tx_ready_out = 0 in the drop cycle; output ALIGN next edge; pattern restarts with an ALIGN pair; the held word is sent at the first data slot.
- RX stream SYNC, ALIGN, 32'h12345678 (charisk 0), ALIGN with phy_err_in = 4'b0010 → rx_valid_out = 1,0,1,0 and rx_err_out = 0,0,0,1, one cycle later.
- SATA_ALIGN_STATS_EN defined: 70000 received ALIGNs → rx_align_cnt = 16'hFFFF; stats_clr pulse concurrent with an ALIGN → rx_align_cnt = 0.
